// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one cache request per memory instruction,
// stalls the EX latch until the access completes, and registers the MEM/WB result.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_write_en,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic [31:0] alu_result,
   input  logic [31:0] read_data_2,
   input  logic [4:0]  rd_num,
   input  logic        is_mem_inst,
   input  logic        is_word,
   input  logic        halted,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        cache_done,
   output logic        reg_write_out,
   output logic        mem_to_reg_out,
   output logic        halted_out,
   output logic [4:0]  rd_num_out,
   output logic [31:0] wb_data_out
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nxt;
   logic        acc;
   logic        wb_load;
   logic [31:0] rdata_q;
   logic [7:0]  load_byte;
   logic [31:0] load_val;

   // a halted instruction is treated as a bubble and never reaches the cache
   assign acc = is_mem_inst & ~halted;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc) state_nxt = mem_ack ? DONE : BUSY;
         BUSY:    if (mem_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      cache_done = 1'b0;
      wb_load    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               mem_req    = acc;
               cache_done = acc;
               wb_load    = ~acc;
            end
            BUSY: begin
               mem_req    = 1'b1;
               cache_done = 1'b1;
            end
            DONE:    wb_load = 1'b1;
            default: ;
         endcase
      end
   end

   // request fields come straight from the latch, which is frozen while stalled
   assign mem_we    = mem_write_en;
   assign mem_addr  = {alu_result[31:2], 2'b00};
   assign mem_wdata = is_word ? read_data_2 : {4{read_data_2[7:0]}};
   assign mem_wmask = is_word ? 4'b1111 : (4'b0001 << alu_result[1:0]);

   always_ff @(posedge clk) begin
      if (rst)                    rdata_q <= 32'h0;
      else if (mem_req & mem_ack) rdata_q <= mem_rdata;
   end

   assign load_byte = rdata_q[{alu_result[1:0], 3'b000} +: 8];
   assign load_val  = is_word ? rdata_q : {{24{load_byte[7]}}, load_byte};

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_out  <= 1'b0;
         mem_to_reg_out <= 1'b0;
         halted_out     <= 1'b0;
         rd_num_out     <= 5'd0;
         wb_data_out    <= 32'h0;
      end else if (wb_load) begin
         reg_write_out  <= reg_write;
         mem_to_reg_out <= mem_to_reg;
         halted_out     <= halted;
         rd_num_out     <= rd_num;
         wb_data_out    <= (mem_to_reg & acc) ? load_val : alu_result;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the bench plays both the EX latch and
// the data cache, and a monitor compares each MEM/WB writeback against a queue.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_write_en = 0, mem_to_reg = 0, reg_write = 0;
   logic [31:0] alu_result = 0, read_data_2 = 0;
   logic [4:0]  rd_num = 0;
   logic        is_mem_inst = 0, is_word = 0, halted = 0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ack = 0;
   logic [31:0] mem_rdata = 0;
   logic        cache_done;
   logic        reg_write_out, mem_to_reg_out, halted_out;
   logic [4:0]  rd_num_out;
   logic [31:0] wb_data_out;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_write_en(mem_write_en), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_result(alu_result), .read_data_2(read_data_2), .rd_num(rd_num),
      .is_mem_inst(is_mem_inst), .is_word(is_word), .halted(halted),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .cache_done(cache_done),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
      .halted_out(halted_out), .rd_num_out(rd_num_out), .wb_data_out(wb_data_out)
   );

   typedef struct packed {
      logic        rw;
      logic        m2r;
      logic        hlt;
      logic [4:0]  rd;
      logic [31:0] wb;
   } wb_t;

   typedef struct {
      logic        we, m2r, rw, mi, word, hlt;
      logic [31:0] alu, d;
      logic [4:0]  rd;
      int          dly;
   } ins_t;

   wb_t         exp_q[$];
   int          n_chk = 0, n_fail = 0;
   logic [31:0] rmem [1024];   // reference model memory, updated in program order
   logic [31:0] cmem [1024];   // cache responder's memory, updated from DUT writes

   ins_t        cur;
   logic        cur_valid = 0;
   logic        cur_acc = 0;
   logic [31:0] exp_wdata;
   logic [3:0]  exp_wmask;
   int          hold_cnt, req_cyc, ack_cnt, req_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic ins_t mk(input logic we, m2r, rw, mi, word, hlt,
                               input logic [31:0] alu, d, input logic [4:0] rd, input int dly);
      ins_t i;
      i.we = we; i.m2r = m2r; i.rw = rw; i.mi = mi; i.word = word; i.hlt = hlt;
      i.alu = alu; i.d = d; i.rd = rd; i.dly = dly;
      return i;
   endfunction

   task automatic finish_check();
      int exp_cyc;
      exp_cyc = cur_acc ? cur.dly + 1 : 0;
      chk("stall_cycles", hold_cnt, exp_cyc);
      chk("req_cycles", req_cyc, exp_cyc);
      chk("ack_count", ack_cnt, cur_acc ? 1 : 0);
   endtask

   // Present an instruction at the EX latch and record its expected writeback.
   task automatic present(input ins_t i);
      logic [31:0] w, ld;
      logic [7:0]  b;
      logic [9:0]  idx;
      logic [3:0]  m;
      wb_t         e;
      if (cur_valid) finish_check();
      cur = i; cur_valid = 1;
      hold_cnt = 0; req_cyc = 0; ack_cnt = 0; req_cnt = 0;
      mem_write_en = i.we; mem_to_reg = i.m2r; reg_write = i.rw;
      alu_result = i.alu; read_data_2 = i.d; rd_num = i.rd;
      is_mem_inst = i.mi; is_word = i.word; halted = i.hlt;
      cur_acc = i.mi && !i.hlt;
      idx = i.alu[11:2];
      w = rmem[idx];
      b = w[8*i.alu[1:0] +: 8];
      ld = i.word ? w : {{24{b[7]}}, b};
      if (cur_acc && i.we) begin
         if (i.word) rmem[idx] = i.d;
         else        rmem[idx][8*i.alu[1:0] +: 8] = i.d[7:0];
      end
      exp_wdata = i.word ? i.d : {4{i.d[7:0]}};
      m = 4'b0001;
      exp_wmask = i.word ? 4'b1111 : (m << i.alu[1:0]);
      e.rw = i.rw; e.m2r = i.m2r; e.hlt = i.hlt; e.rd = i.rd;
      e.wb = (i.m2r && cur_acc) ? ld : i.alu;
      exp_q.push_back(e);
   endtask

   // Cache side: ack after cur.dly request cycles; random ack noise while idle.
   task automatic cache_resp();
      if (mem_req) begin
         req_cyc++;
         chk("req_only_for_mem_access", {31'b0, cur_acc}, 32'd1);
         if (req_cnt == cur.dly) begin
            mem_ack = 1;
            mem_rdata = cmem[mem_addr[11:2]];
            ack_cnt++;
            chk("mem_addr", mem_addr, {cur.alu[31:2], 2'b00});
            chk("mem_we", {31'b0, mem_we}, {31'b0, cur.we});
            if (cur.we) begin
               chk("mem_wdata", mem_wdata, exp_wdata);
               chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, exp_wmask});
               for (int k = 0; k < 4; k++)
                  if (mem_wmask[k]) cmem[mem_addr[11:2]][8*k +: 8] = mem_wdata[8*k +: 8];
            end
         end else begin
            mem_ack = 0;
            mem_rdata = $urandom;
            req_cnt++;
         end
      end else begin
         mem_ack = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
      end
   endtask

   task automatic do_reset(input bit keep_inputs);
      ins_t bub;
      bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1; mem_ack = 0; exp_q.delete(); cur_valid = 0;
      if (!keep_inputs) present(bub);
      exp_q.delete(); cur_valid = 0;
      #1;
      chk("req_during_reset", {31'b0, mem_req}, 0);
      chk("done_during_reset", {31'b0, cache_done}, 0);
      @(negedge clk);
      rst = 0;
      present(bub);
      #1;
      chk("req_after_reset", {31'b0, mem_req}, 0);
      chk("done_after_reset", {31'b0, cache_done}, 0);
      chk("wb_data_reset", wb_data_out, 0);
      chk("wb_ctrl_reset", {24'b0, reg_write_out, mem_to_reg_out, halted_out, rd_num_out}, 0);
      cache_resp();
      #1;
   endtask

   task automatic run_ins(input ins_t i);
      int cyc;
      @(negedge clk);
      present(i);
      cyc = 0;
      forever begin
         #1 cache_resp();
         #1;
         if (!cache_done) break;
         hold_cnt++;
         cyc++;
         if (cyc > 50) begin
            n_chk++; n_fail++;
            $display("FAIL stall_timeout: cache_done still %0d after %0d cycles", cache_done, cyc);
            do_reset(0);
            break;
         end
         @(negedge clk);
      end
   endtask

   // Monitor: a cycle with cache_done low (outside reset) retires one writeback.
   logic pend = 0;
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL wb_unexpected: got wb %h with nothing expected", wb_data_out);
            end else begin
               e = exp_q.pop_front();
               chk("wb_data", wb_data_out, e.wb);
               chk("wb_ctrl", {24'b0, reg_write_out, mem_to_reg_out, halted_out, rd_num_out},
                   {24'b0, e.rw, e.m2r, e.hlt, e.rd});
            end
         end
         #2 pend = !cache_done && !rst;
      end
   end

   initial begin
      ins_t r;
      int   kind;
      for (int k = 0; k < 1024; k++) begin
         rmem[k] = $urandom;
         cmem[k] = rmem[k];
      end
      rmem[32'h100 >> 2] = 32'hDEADBEEF; cmem[32'h100 >> 2] = 32'hDEADBEEF;
      rmem[32'h200 >> 2] = 32'h80112233; cmem[32'h200 >> 2] = 32'h80112233;

      do_reset(0);
      //       we m2r rw mi word hlt alu           d             rd  dly
      run_ins(mk(0, 1, 1, 1, 1, 0, 32'h100,      32'h0,        5,  2));
      run_ins(mk(0, 1, 1, 1, 0, 0, 32'h203,      32'h0,        6,  0));
      run_ins(mk(0, 1, 1, 1, 0, 0, 32'h201,      32'h0,        7,  0));
      run_ins(mk(1, 0, 0, 1, 0, 0, 32'h402,      32'h000000A5, 0,  1));
      run_ins(mk(0, 0, 1, 0, 1, 0, 32'h12345678, 32'h0,        3,  0));
      run_ins(mk(1, 0, 0, 1, 1, 0, 32'h300,      32'hCAFEF00D, 0,  1));
      run_ins(mk(0, 1, 1, 1, 1, 0, 32'h300,      32'h0,        9,  1));
      run_ins(mk(1, 0, 0, 1, 1, 1, 32'h300,      32'h0,        0,  0));
      run_ins(mk(0, 1, 1, 1, 0, 0, 32'h302,      32'h0,        4,  0));

      // reset while a load is stuck waiting for an ack that never comes
      @(negedge clk);
      present(mk(0, 1, 1, 1, 1, 0, 32'h104, 32'h0, 8, 1000));
      repeat (3) begin
         #1 cache_resp();
         #1 chk("stalled_before_reset", {31'b0, cache_done}, 1);
         @(negedge clk);
      end
      #2;
      do_reset(1);

      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 2);
         r = mk(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                $urandom, $urandom, 5'($urandom), $urandom_range(0, 3));
         if (kind == 1) begin
            r.mi = 1; r.m2r = 1; r.rw = 1; r.alu = $urandom_range(0, 32'hFFF);
         end else if (kind == 2) begin
            r.mi = 1; r.we = 1; r.m2r = 0; r.rw = 0; r.alu = $urandom_range(0, 32'hFFF);
         end
         run_ins(r);
      end

      @(negedge clk);
      #1;
      if (cur_valid) finish_check();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
